// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_ctrl
//  Description : Load/store unit between the MEM stage and the data-memory
//                port. It generates byte enables, steers store data into the
//                correct lanes and sign/zero-extends load data. It runs a
//                req/gnt/rvalid memory handshake with one transaction
//                outstanding.
//  Parameters  : XLEN   - datapath width, 32 or 64 (B = XLEN/8 byte lanes)
//                ADDR_W - byte-address width
//  Ports       : clk, rst (async, active-high)
//                req_*  - MEM-stage request (valid/ready, we, size, unsigned,
//                         addr, wdata)
//                mem_*  - memory port (req, we, addr, be, wdata, gnt,
//                         rvalid, rdata)
//                resp_* - one-cycle completion (valid, data, err)
//  Option      : LSU_MISALIGN_SPLIT_EN - when defined, misaligned accesses
//                are executed, and lane-crossing ones are split into two
//                aligned beats. When undefined, every naturally misaligned
//                access is rejected with resp_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_data,
    output logic                  resp_err
);

    localparam int c_B     = XLEN / 8;
    localparam int c_OFS_W = $clog2(c_B);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ1  = 3'd1,
        S_WAIT1 = 3'd2,
        S_REQ2  = 3'd3,
        S_WAIT2 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Request fields captured at accept
    logic                 r_we;
    logic [1:0]           r_size;
    logic                 r_uns;
    logic [c_OFS_W-1:0]   r_ofs;
    logic [ADDR_W-1:0]    r_base;
    logic [c_B-1:0]       r_be1;
    logic [c_B-1:0]       r_be2;
    logic [XLEN-1:0]      r_wdata;
    logic                 r_split;
    logic                 r_err;
    logic [XLEN-1:0]      r_rd1;
    logic [XLEN-1:0]      r_rd2;

    // Accept-time decode
    logic [c_OFS_W-1:0]   w_ofs;
    int                   w_ofs_i;
    int                   w_nb_i;
    logic                 w_bad_size;
    logic                 w_err;
    logic                 w_split;
    logic [c_B-1:0]       w_be1;
    logic [c_B-1:0]       w_be2;
    logic [XLEN-1:0]      w_rot;
    logic                 w_accept;

    // Load extension
    logic [XLEN-1:0]      w_lsh;
    int                   w_nbits;
    logic                 w_fill;
    logic [XLEN-1:0]      w_ext;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_ofs      = req_addr[c_OFS_W-1:0];
        w_ofs_i    = int'(w_ofs);
        w_nb_i     = 1 << req_size;
        w_bad_size = (XLEN == 32) && (req_size == 2'd3);
`ifdef LSU_MISALIGN_SPLIT_EN
        w_err      = w_bad_size;
        w_split    = !w_bad_size && ((w_ofs_i + w_nb_i) > c_B);
`else
        w_err      = w_bad_size || ((w_ofs_i % w_nb_i) != 0);
        w_split    = 1'b0;
`endif
        // Beat 1 covers lanes from the offset up to the top lane; whatever
        // spills past the top lands in the low lanes of beat 2.
        for (int l = 0; l < c_B; l++) begin
            w_be1[l] = (l >= w_ofs_i) && (l < (w_ofs_i + w_nb_i));
            w_be2[l] = (l < (w_ofs_i + w_nb_i - c_B));
        end
        // A single-beat load reads the full word and extracts the bytes it needs.
        if (!req_we && !w_split) begin
            w_be1 = '1;
        end
        // Rotate left by ofs bytes: the low XLEN bits of the doubled word,
        // shifted right by (XLEN - ofs*8)
        w_rot = XLEN'({req_wdata, req_wdata} >> (XLEN - int'({w_ofs, 3'b000})));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)  w_state_nxt = w_err ? S_RESP : S_REQ1;
            S_REQ1:  if (mem_gnt)    w_state_nxt = S_WAIT1;
            S_WAIT1: if (mem_rvalid) w_state_nxt = r_split ? S_REQ2 : S_RESP;
            S_REQ2:  if (mem_gnt)    w_state_nxt = S_WAIT2;
            S_WAIT2: if (mem_rvalid) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_ofs   <= '0;
            r_base  <= '0;
            r_be1   <= '0;
            r_be2   <= '0;
            r_wdata <= '0;
            r_split <= 1'b0;
            r_err   <= 1'b0;
            r_rd1   <= '0;
            r_rd2   <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_ofs   <= w_ofs;
                r_base  <= {req_addr[ADDR_W-1:c_OFS_W], {c_OFS_W{1'b0}}};
                r_be1   <= w_be1;
                r_be2   <= w_be2;
                r_wdata <= w_rot;
                r_split <= w_split;
                r_err   <= w_err;
            end
            if ((r_state == S_WAIT1) && mem_rvalid) begin
                r_rd1 <= mem_rdata;
            end
            if ((r_state == S_WAIT2) && mem_rvalid) begin
                r_rd2 <= mem_rdata;
            end
        end
    end

    // Load merge: beat 2 sits above beat 1, so shifting the pair right by the
    // offset packs the requested bytes little-endian from bit 0. For a single
    // beat, the stale beat-2 bytes fall above nbytes and are replaced by the fill.
    always_comb begin
        w_lsh   = XLEN'({r_rd2, r_rd1} >> {r_ofs, 3'b000});
        w_nbits = 8 << r_size;
        case (r_size)
            2'd0:    w_fill = w_lsh[7];
            2'd1:    w_fill = w_lsh[15];
            2'd2:    w_fill = w_lsh[31];
            default: w_fill = w_lsh[XLEN-1];
        endcase
        if (r_uns) begin
            w_fill = 1'b0;
        end
        for (int i = 0; i < XLEN; i++) begin
            w_ext[i] = (i < w_nbits) ? w_lsh[i] : w_fill;
        end
    end

    // Outputs are decoded from the state register so that mem_req drops as
    // soon as the asynchronous reset hits.
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        mem_req    = (r_state == S_REQ1) || (r_state == S_REQ2);
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        resp_valid = (r_state == S_RESP);
        resp_err   = 1'b0;
        resp_data  = '0;
        if (mem_req) begin
            mem_we    = r_we;
            mem_addr  = (r_state == S_REQ2) ? (r_base + ADDR_W'(c_B)) : r_base;
            mem_be    = (r_state == S_REQ2) ? r_be2 : r_be1;
            mem_wdata = r_we ? r_wdata : '0;
        end
        if (resp_valid) begin
            resp_err  = r_err;
            resp_data = (r_we || r_err) ? '0 : w_ext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_ctrl
//  Description : Self-checking bench for lsu_mem_ctrl at XLEN=32. A
//                byte-addressed reference memory predicts load results,
//                beat layout and store effects. A separate responder memory
//                serves the DUT with random grant and rvalid delays.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    lsu_mem_ctrl #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Memories: dmem is what the DUT reads and writes, rmem is the reference
    logic [31:0] dmem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];

    // Beat log filled by the responder at each grant
    logic [31:0] q_addr [$];
    logic [3:0]  q_be   [$];
    logic        q_we   [$];
    logic [31:0] q_wd   [$];

    int gnt_force = -1;
    int rv_force  = -1;
    bit spur_en   = 1'b0;
    int last_hold = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F17;
    endfunction

    function automatic logic [31:0] dm_rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rm_rd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_word(a);
    endfunction

    function automatic logic [7:0] rm_byte(input logic [31:0] a);
        logic [31:0] w;
        w = rm_rd({a[31:2], 2'b00});
        return w[a[1:0]*8 +: 8];
    endfunction

    function automatic void rm_wbyte(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] w;
        w = rm_rd({a[31:2], 2'b00});
        w[a[1:0]*8 +: 8] = b;
        rmem[{a[31:2], 2'b00}] = w;
    endfunction

    function automatic logic [31:0] bemask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int l = 0; l < 4; l++) m[l*8 +: 8] = be[l] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        dmem[a] = w;
        rmem[a] = w;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: samples on the falling edge and drives gnt/rvalid
    // for the next rising edge
    bit          pending = 1'b0;
    int          rv_cnt  = 0;
    int          gnt_wait = -1;
    int          hold    = 0;
    logic [31:0] pend_data;

    always @(negedge clk) begin
        logic [31:0] w;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (rst) begin
            pending  = 1'b0;
            gnt_wait = -1;
            hold     = 0;
        end else if (pending) begin
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
                pending    = 1'b0;
            end else begin
                rv_cnt--;
            end
        end else if (mem_req) begin
            hold++;
            if (gnt_wait < 0) gnt_wait = (gnt_force >= 0) ? gnt_force : int'($urandom_range(0, 3));
            if (gnt_wait == 0) begin
                mem_gnt = 1'b1;
                q_addr.push_back(mem_addr);
                q_be.push_back(mem_be);
                q_we.push_back(mem_we);
                q_wd.push_back(mem_wdata);
                last_hold = hold;
                hold      = 0;
                gnt_wait  = -1;
                w = dm_rd(mem_addr);
                if (mem_we) begin
                    for (int l = 0; l < 4; l++)
                        if (mem_be[l]) w[l*8 +: 8] = mem_wdata[l*8 +: 8];
                    dmem[mem_addr] = w;
                    pend_data = $urandom;
                end else begin
                    pend_data = w;
                end
                pending = 1'b1;
                rv_cnt  = (rv_force >= 0) ? rv_force : int'($urandom_range(0, 3));
            end else begin
                gnt_wait--;
                if (spur_en && ($urandom_range(0, 1) == 1)) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                end
            end
        end
    end

    // One complete transaction, checked against the byte-level reference
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat);
        int          n;
        int          enb;
        int          b;
        int          k;
        bit          got;
        logic        ex_err;
        logic [31:0] ex_data;
        logic [31:0] base;
        logic [31:0] ba;
        logic [3:0]  ebe [2];
        logic [31:0] ewd [2];

        n       = 1 << size;
        base    = {addr[31:2], 2'b00};
        ex_err  = (size == 2'd3) || (!SPLIT && ((int'(addr[1:0]) % n) != 0));
        ex_data = '0;
        enb     = 0;
        ebe[0]  = '0; ebe[1] = '0;
        ewd[0]  = '0; ewd[1] = '0;
        if (!ex_err) begin
            enb = 1;
            for (int i = 0; i < n; i++) begin
                ba = addr + 32'(i);
                b  = ({ba[31:2], 2'b00} == base) ? 0 : 1;
                if (b == 1) enb = 2;
                ebe[b][ba[1:0]] = 1'b1;
                if (we) begin
                    ewd[b][ba[1:0]*8 +: 8] = wdata[i*8 +: 8];
                    rm_wbyte(ba, wdata[i*8 +: 8]);
                end else begin
                    ex_data[i*8 +: 8] = rm_byte(ba);
                end
            end
            if (!we && !uns && n < 4 && ex_data[n*8-1]) ex_data = ex_data | ~((32'd1 << (n*8)) - 32'd1);
            if (!we && enb == 1) ebe[0] = 4'hF;
        end

        @(negedge clk);
        check("ready_before", {63'd0, req_ready}, 64'd1);
        q_addr.delete(); q_be.delete(); q_we.delete(); q_wd.delete();
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        got = 1'b0;
        for (k = 1; k <= 100; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("resp_timeout", {63'd0, got}, 64'd1);
        if (!got) return;
        if (exp_lat > 0) check("latency", 64'(k), 64'(exp_lat));
        check("resp_err", {63'd0, resp_err}, {63'd0, ex_err});
        check("resp_data", {32'd0, resp_data}, {32'd0, ex_data});
        check("beat_count", 64'(q_addr.size()), 64'(enb));
        for (int j = 0; j < enb && j < q_addr.size(); j++) begin
            check("beat_addr", {32'd0, q_addr[j]}, {32'd0, base + 32'(4*j)});
            check("beat_be", {60'd0, q_be[j]}, {60'd0, ebe[j]});
            check("beat_we", {63'd0, q_we[j]}, {63'd0, we});
            if (we) check("beat_wdata", {32'd0, q_wd[j] & bemask(ebe[j])}, {32'd0, ewd[j]});
        end
        if (we && !ex_err) begin
            check("mem_word0", {32'd0, dm_rd(base)}, {32'd0, rm_rd(base)});
            if (enb == 2) check("mem_word1", {32'd0, dm_rd(base + 32'd4)}, {32'd0, rm_rd(base + 32'd4)});
        end
        @(negedge clk);
        check("resp_one_cycle", {63'd0, resp_valid}, 64'd0);
        check("ready_after", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        bit          seen;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_err", {63'd0, resp_err}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_mem_be", {60'd0, mem_be}, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_resp_data", {32'd0, resp_data}, 64'd0);
        rst = 1'b0;

        // Directed cases with immediate grant and rvalid
        gnt_force = 0; rv_force = 0;
        set_word(32'h1000, 32'h80AA_BBCC);
        do_txn(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 3);          // LB
        set_word(32'h2000, 32'h1234_5678);
        do_txn(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 3);          // LHU
        set_word(32'h2000, 32'h8000_5678);
        do_txn(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 3);          // LH

        gnt_force = 3;
        do_txn(1'b1, 2'd0, 1'b0, 32'h3001, 32'h0000_00EE, -1); // SB, gnt late
        check("sb_req_hold", 64'(last_hold), 64'd4);
        if (q_wd.size() > 0) check("sb_lane1", {56'd0, q_wd[0][15:8]}, 64'hEE);
        gnt_force = 0;

        set_word(32'h4000, 32'hDDCC_0000);
        set_word(32'h4004, 32'h0000_BBAA);
        do_txn(1'b0, 2'd2, 1'b0, 32'h4002, 32'h0, -1);         // LW crossing
        do_txn(1'b0, 2'd3, 1'b0, 32'h4000, 32'h0, 1);          // illegal size
        do_txn(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, -1);    // wraps past top
        do_txn(1'b1, 2'd1, 1'b0, 32'h6003, 32'hA1B2_C3D4, -1); // SH crossing

        // Reset while waiting for rvalid
        rv_force = 10;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h5000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_req", {63'd0, mem_req}, 64'd0);
        check("midrst_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("midrst_no_resp", {63'd0, seen}, 64'd0);
        rv_force = 0;
        do_txn(1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 3);

        // Randomized traffic with random delays and stray rvalid pulses
        gnt_force = -1; rv_force = -1; spur_en = 1'b1;
        for (int t = 0; t < 200; t++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           a = 32'h0000_8000 + 32'($urandom_range(0, 31));
            do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
